// File: rtl/sprite_blit_engine.sv
// -----------------------------------------------------------------------------
// sprite_blit_engine
// Reader side of the sprite ROM. It accepts one rectangular draw request at a
// time and walks the sprite row-major through the ROM. For each ROM word it
// emits one framebuffer pixel slot, at a sustained rate of one pixel per clock.
//
// Ports
//   i_clock, i_reset        system clock; synchronous active-high reset
//   i_req_valid/o_req_ready draw request handshake (ready only when idle)
//   i_req_base/w/h/x/y      sprite ROM base, size and screen position
//   i_req_flip              horizontal mirror request
//   o_rom_addr / i_rom_q    registered ROM address; index returned one clock later
//   o_fb_we/i_fb_ready      pixel write handshake
//   o_fb_x/o_fb_y/o_fb_idx  pixel write payload, held while stalled
//   o_busy                  high from accept through the done cycle
//   o_done                  one-clock completion pulse
//
// Build option: define SPRITE_HFLIP_EN to enable horizontal mirroring.
// Without it, i_req_flip is accepted but ignored.
// -----------------------------------------------------------------------------
module sprite_blit_engine #(
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 5,
    parameter int DIM_W      = 9,
    parameter int FB_X_W     = 10,
    parameter int FB_Y_W     = 9,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int TRANSP_IDX = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_base,
    input  logic [DIM_W-1:0]  i_req_w,
    input  logic [DIM_W-1:0]  i_req_h,
    input  logic [FB_X_W-1:0] i_req_x,
    input  logic [FB_Y_W-1:0] i_req_y,
    input  logic              i_req_flip,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [IDX_W-1:0]  i_rom_q,
    output logic              o_fb_we,
    input  logic              i_fb_ready,
    output logic [FB_X_W-1:0] o_fb_x,
    output logic [FB_Y_W-1:0] o_fb_y,
    output logic [IDX_W-1:0]  o_fb_idx,
    output logic              o_busy,
    output logic              o_done
);
    localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0]  DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [FB_X_W:0]   SCR_W_L   = SCREEN_W[FB_X_W:0];
    localparam logic [FB_Y_W:0]   SCR_H_L   = SCREEN_H[FB_Y_W:0];
    localparam logic [IDX_W-1:0]  TRANSP_L  = TRANSP_IDX[IDX_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Latched request and address-walk state
    logic [DIM_W-1:0]  r_w, r_h, r_col, r_row;
    logic [FB_X_W-1:0] r_x;
    logic [FB_Y_W-1:0] r_y;
    logic [ADDR_W-1:0] r_row_base, r_rom_addr;
    // S0 tag (pixel whose address sits in r_rom_addr)
    logic              r_s0_vld, r_s0_last;
    logic [FB_X_W:0]   r_s0_x;
    logic [FB_Y_W:0]   r_s0_y;
    // S1 tag (aligned with i_rom_q) plus a capture of i_rom_q taken on the
    // first stalled edge: the ROM re-reads the held S0 address while stalled,
    // so the S1 word would otherwise be overwritten.
    logic              r_s1_vld, r_s1_last, r_s1_held;
    logic [FB_X_W:0]   r_s1_x;
    logic [FB_Y_W:0]   r_s1_y;
    logic [IDX_W-1:0]  r_s1_hold_q;
    // S2 output stage
    logic              r_fb_we, r_s2_last;
    logic [FB_X_W-1:0] r_fb_x;
    logic [FB_Y_W-1:0] r_fb_y;
    logic [IDX_W-1:0]  r_fb_idx;
    logic              r_req_ready, r_busy, r_done;

    logic              w_advance, w_accept, w_zero, w_acc_last, w_nxt_last;
    logic [DIM_W-1:0]  w_nxt_col, w_nxt_row, w_nxt_off, w_acc_off;
    logic [ADDR_W-1:0] w_nxt_row_base;
    logic [IDX_W-1:0]  w_s1_q;

    assign w_advance  = !r_fb_we || i_fb_ready;
    assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
    assign w_zero     = (i_req_w == DIM_ZERO) || (i_req_h == DIM_ZERO);
    assign w_acc_last = (i_req_w == DIM_ONE) && (i_req_h == DIM_ONE);
    assign w_s1_q     = r_s1_held ? r_s1_hold_q : i_rom_q;
    assign w_nxt_last = (w_nxt_col == r_w - DIM_ONE) && (w_nxt_row == r_h - DIM_ONE);

`ifdef SPRITE_HFLIP_EN
    logic r_flip;
    // Mirrored rows read from the right edge of the stored row towards the left
    assign w_nxt_off = r_flip ? (r_w - DIM_ONE - w_nxt_col) : w_nxt_col;
    assign w_acc_off = i_req_flip ? (i_req_w - DIM_ONE) : DIM_ZERO;

    // Flip flag latched with the request
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flip <= 1'b0;
        end else if (w_accept) begin
            r_flip <= i_req_flip;
        end
    end
`else
    logic w_unused_flip;
    assign w_unused_flip = i_req_flip;
    assign w_nxt_off     = w_nxt_col;
    assign w_acc_off     = DIM_ZERO;
`endif

    // Next walk position: step along the row, or wrap and add w to the row base
    always_comb begin
        w_nxt_col      = r_col + DIM_ONE;
        w_nxt_row      = r_row;
        w_nxt_row_base = r_row_base;
        if (r_col == r_w - DIM_ONE) begin
            w_nxt_col      = DIM_ZERO;
            w_nxt_row      = r_row + DIM_ONE;
            w_nxt_row_base = r_row_base + {{(ADDR_W-DIM_W){1'b0}}, r_w};
        end else begin
            w_nxt_row_base = r_row_base;
        end
    end

    // FSM next state; DRAIN ends when the tail token leaves S2
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? ST_DRAIN : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_advance && r_s0_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_advance && r_s2_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register and registered status outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    // Three-stage pixel pipeline; every stage moves only on advance
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_w <= DIM_ZERO;  r_h <= DIM_ZERO;  r_col <= DIM_ZERO;  r_row <= DIM_ZERO;
            r_x <= {FB_X_W{1'b0}};  r_y <= {FB_Y_W{1'b0}};
            r_row_base <= {ADDR_W{1'b0}};  r_rom_addr <= {ADDR_W{1'b0}};
            r_s0_vld <= 1'b0;  r_s0_last <= 1'b0;
            r_s0_x <= {(FB_X_W+1){1'b0}};  r_s0_y <= {(FB_Y_W+1){1'b0}};
            r_s1_vld <= 1'b0;  r_s1_last <= 1'b0;  r_s1_held <= 1'b0;
            r_s1_x <= {(FB_X_W+1){1'b0}};  r_s1_y <= {(FB_Y_W+1){1'b0}};
            r_s1_hold_q <= {IDX_W{1'b0}};
            r_fb_we <= 1'b0;  r_s2_last <= 1'b0;
            r_fb_x <= {FB_X_W{1'b0}};  r_fb_y <= {FB_Y_W{1'b0}};  r_fb_idx <= {IDX_W{1'b0}};
        end else if (w_advance) begin
            // S2: transparent or off-screen pixels keep their slot but do not write
            r_fb_we   <= r_s1_vld && (w_s1_q != TRANSP_L) &&
                         (r_s1_x < SCR_W_L) && (r_s1_y < SCR_H_L);
            r_fb_x    <= r_s1_x[FB_X_W-1:0];
            r_fb_y    <= r_s1_y[FB_Y_W-1:0];
            r_fb_idx  <= w_s1_q;
            r_s2_last <= r_s1_last;
            // S1
            r_s1_vld  <= r_s0_vld;
            r_s1_last <= r_s0_last;
            r_s1_x    <= r_s0_x;
            r_s1_y    <= r_s0_y;
            r_s1_held <= 1'b0;
            // S0
            if (w_accept) begin
                r_w <= i_req_w;  r_h <= i_req_h;  r_x <= i_req_x;  r_y <= i_req_y;
                r_col      <= DIM_ZERO;
                r_row      <= DIM_ZERO;
                r_row_base <= i_req_base;
                r_rom_addr <= i_req_base + {{(ADDR_W-DIM_W){1'b0}}, w_acc_off};
                r_s0_x     <= {1'b0, i_req_x};
                r_s0_y     <= {1'b0, i_req_y};
                if (w_zero) begin
                    // Empty sprite: inject only the tail token straight into S1
                    r_s0_vld  <= 1'b0;
                    r_s0_last <= 1'b0;
                    r_s1_last <= 1'b1;
                end else begin
                    r_s0_vld  <= 1'b1;
                    r_s0_last <= w_acc_last;
                end
            end else if ((r_state == ST_RUN) && !r_s0_last) begin
                r_col      <= w_nxt_col;
                r_row      <= w_nxt_row;
                r_row_base <= w_nxt_row_base;
                r_rom_addr <= w_nxt_row_base + {{(ADDR_W-DIM_W){1'b0}}, w_nxt_off};
                r_s0_vld   <= 1'b1;
                r_s0_last  <= w_nxt_last;
                r_s0_x     <= {1'b0, r_x} + {{(FB_X_W+1-DIM_W){1'b0}}, w_nxt_col};
                r_s0_y     <= {1'b0, r_y} + {{(FB_Y_W+1-DIM_W){1'b0}}, w_nxt_row};
            end else begin
                r_s0_vld  <= 1'b0;
                r_s0_last <= 1'b0;
            end
        end else if (!r_s1_held) begin
            r_s1_hold_q <= i_rom_q;
            r_s1_held   <= 1'b1;
        end else begin
            r_s1_held <= 1'b1;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rom_addr  = r_rom_addr;
    assign o_fb_we     = r_fb_we;
    assign o_fb_x      = r_fb_x;
    assign o_fb_y      = r_fb_y;
    assign o_fb_idx    = r_fb_idx;

endmodule
